// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM state encoding and port-count limit.
package sdram_arb_pkg;

  localparam int MAX_PORTS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Client-port and SDRAM-side bundle for sdram_port_arbiter; slave = arbiter, master = clients plus SDRAM.
interface sdram_port_arbiter_if #(
  parameter int PORTS  = 3,
  parameter int A_BITS = 24
);
  localparam int GW = $clog2(PORTS);

  logic [PORTS-1:0]        req;
  logic [PORTS-1:0]        ack;
  logic [PORTS-1:0]        we;
  logic [PORTS*A_BITS-1:0] a;
  logic [PORTS*8-1:0]      d;
  logic [PORTS*8-1:0]      q;
  logic                    ram_req;
  logic                    ram_ack;
  logic                    ram_we;
  logic [A_BITS-1:0]       ram_a;
  logic [7:0]              ram_d;
  logic [7:0]              ram_q;
  logic [GW-1:0]           grant;
  logic                    busy;

  modport slave (
    input  req, we, a, d, ram_ack, ram_q,
    output ack, q, ram_req, ram_we, ram_a, ram_d, grant, busy
  );

  modport master (
    output req, we, a, d, ram_ack, ram_q,
    input  ack, q, ram_req, ram_we, ram_a, ram_d, grant, busy
  );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner selection for the SDRAM port arbiter.
// SDRAM_ARB_ROUND_ROBIN_EN: search starts at ptr+1 (mod PORTS); otherwise lowest index wins.
module arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int PORTS = 3,
  parameter int PW    = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] pending,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    idx,
  output logic             valid
);

  int          start_s;
  int          j_s;
  logic        hit_s;
  logic [PW-1:0] idx_s;
  logic        valid_s;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  assign start_s = (int'(ptr) + 1) % PORTS;
`else
  logic unused_ptr_s;
  assign unused_ptr_s = ^ptr;
  assign start_s      = 0;
`endif

  // First pending port in circular order from start_s
  always_comb begin
    idx_s   = '0;
    valid_s = 1'b0;
    j_s     = 0;
    hit_s   = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      j_s     = (start_s + k) % PORTS;
      hit_s   = !valid_s && pending[j_s];
      idx_s   = hit_s ? PW'(j_s) : idx_s;
      valid_s = valid_s | hit_s;
    end
  end

  assign idx   = idx_s;
  assign valid = valid_s;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates PORTS toggle-handshake byte clients onto one toggle-handshake SDRAM byte port.
// Optional macro SDRAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int PORTS  = 3,
  parameter int A_BITS = 24
) (
  input logic                 clk,
  input logic                 reset_n,
  sdram_port_arbiter_if.slave bus
);

  localparam int PW = $clog2(PORTS);

  arb_state_t            state_r, state_s;
  logic [PW-1:0]         ptr_r, ptr_s;
  logic [PW-1:0]         grant_r, grant_s;
  logic [PW-1:0]         pick_idx_s;
  logic                  pick_valid_s;
  logic [PORTS-1:0]      ack_r, ack_s;
  logic [PORTS-1:0]      pending_s;
  logic [PORTS*8-1:0]    q_r, q_s;
  logic                  ram_req_r, ram_req_s;
  logic                  ram_we_r, ram_we_s;
  logic [A_BITS-1:0]     ram_a_r, ram_a_s;
  logic [7:0]            ram_d_r, ram_d_s;
  logic                  busy_r;
  logic                  ram_idle_s;

  // A port stays pending for the whole transfer; only IDLE looks at it
  assign pending_s  = bus.req ^ ack_r;
  assign ram_idle_s = (bus.ram_ack == ram_req_r);

  arb_pick #(.PORTS(PORTS), .PW(PW)) u_pick (
    .pending (pending_s),
    .ptr     (ptr_r),
    .idx     (pick_idx_s),
    .valid   (pick_valid_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    grant_s   = grant_r;
    ack_s     = ack_r;
    q_s       = q_r;
    ram_req_s = ram_req_r;
    ram_we_s  = ram_we_r;
    ram_a_s   = ram_a_r;
    ram_d_s   = ram_d_r;
    case (state_r)
      IDLE: begin
        if (ram_idle_s && pick_valid_s) begin
          ram_we_s  = bus.we[pick_idx_s];
          ram_a_s   = bus.a[int'(pick_idx_s)*A_BITS +: A_BITS];
          ram_d_s   = bus.d[int'(pick_idx_s)*8 +: 8];
          grant_s   = pick_idx_s;
          ram_req_s = ~ram_req_r;
          state_s   = WAIT;
        end else begin
          state_s   = IDLE;
        end
      end
      WAIT: begin
        if (ram_idle_s) begin
          if (!ram_we_r) begin
            q_s[int'(grant_r)*8 +: 8] = bus.ram_q;
          end else begin
            q_s = q_r;
          end
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        ack_s[grant_r] = ~ack_r[grant_r];
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        ptr_s = grant_r;
`else
        ptr_s = '0;
`endif
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r     <= '0;
      grant_r   <= '0;
      ack_r     <= '0;
      q_r       <= '0;
      ram_req_r <= 1'b0;
      ram_we_r  <= 1'b0;
      ram_a_r   <= '0;
      ram_d_r   <= 8'h00;
      busy_r    <= 1'b0;
    end else begin
      ptr_r     <= ptr_s;
      grant_r   <= grant_s;
      ack_r     <= ack_s;
      q_r       <= q_s;
      ram_req_r <= ram_req_s;
      ram_we_r  <= ram_we_s;
      ram_a_r   <= ram_a_s;
      ram_d_r   <= ram_d_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  assign bus.ack     = ack_r;
  assign bus.q       = q_r;
  assign bus.ram_req = ram_req_r;
  assign bus.ram_we  = ram_we_r;
  assign bus.ram_a   = ram_a_r;
  assign bus.ram_d   = ram_d_r;
  assign bus.grant   = grant_r;
  assign bus.busy    = busy_r;

endmodule
